// File: rtl/fp_issue_ctrl_pkg.sv
// Shared types and constants for the FP multiply/divide issue stage.
package fp_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MUL = 2'd1,
    ST_WAIT_DIV = 2'd2,
    ST_HOLD     = 2'd3
  } state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  // out_flags bit positions, {io, dz, of, uf, i}
  localparam int unsigned FL_IO  = 4;
  localparam int unsigned FL_DZ  = 3;
  localparam int unsigned FL_OF  = 2;
  localparam int unsigned FL_UF  = 1;
  localparam int unsigned FL_I   = 0;
  localparam int unsigned FLAG_W = 5;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned CNT_W = 8;

  function automatic logic [31:0] signed_inf(input logic s);
    return POS_INF | {s, 31'b0};
  endfunction

  function automatic logic [31:0] signed_zero(input logic s);
    return {s, 31'b0};
  endfunction

endpackage

// File: rtl/fp_issue_ctrl_if.sv
// Request, core and result signals of the FP issue stage.
// master = surrounding environment, slave = fp_issue_ctrl.
interface fp_issue_ctrl_if;
  import fp_issue_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_a;
  logic [31:0]       in_b;
  logic              in_op;

  logic [31:0]       core_a;
  logic [31:0]       core_b;
  logic              core_en;
  logic              core_sel;
  logic              core_done_div;
  logic [31:0]       core_r;
  logic              core_of;
  logic              core_uf;
  logic              core_i;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_r;
  logic [FLAG_W-1:0] out_flags;

  modport master (
    output in_valid, in_a, in_b, in_op,
    output core_done_div, core_r, core_of, core_uf, core_i,
    output out_ready,
    input  in_ready, core_a, core_b, core_en, core_sel,
    input  out_valid, out_r, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op,
    input  core_done_div, core_r, core_of, core_uf, core_i,
    input  out_ready,
    output in_ready, core_a, core_b, core_en, core_sel,
    output out_valid, out_r, out_flags
  );

endinterface

// File: rtl/fp_issue_ctrl_classify.sv
// Combinational IEEE-754 single classifier; subnormals count as zero.
module fp_classify
  import fp_issue_pkg::*;
(
  input  logic [31:0] f,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan,
  output logic        sign
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign exp_f   = f[MAN_W +: EXP_W];
  assign man_f   = f[MAN_W-1:0];
  assign is_zero = (exp_f == '0);
  assign is_inf  = (exp_f == '1) && (man_f == '0);
  assign is_nan  = (exp_f == '1) && (man_f != '0);
  assign sign    = f[EXP_W + MAN_W];

endmodule

// File: rtl/fp_issue_ctrl.sv
// Issue/sequencing stage in front of the FP multiply/divide core.
// Special operands are resolved locally; ordinary ones are held on the
// core until the multiply latency elapses or the divider reports done.
module fp_issue_ctrl
  import fp_issue_pkg::*;
#(
  parameter int unsigned MUL_LAT     = 4,
  parameter int unsigned DIV_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             arst_n,
  fp_issue_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic              sel_q, sel_d;
  logic [31:0]       r_q, r_d;
  logic [FLAG_W-1:0] fl_q, fl_d;

  logic a_zero, a_inf, a_nan, a_sign;
  logic b_zero, b_inf, b_nan, b_sign;

  fp_classify u_cls_a (
    .f       (bus.in_a),
    .is_zero (a_zero),
    .is_inf  (a_inf),
    .is_nan  (a_nan),
    .sign    (a_sign)
  );

  fp_classify u_cls_b (
    .f       (bus.in_b),
    .is_zero (b_zero),
    .is_inf  (b_inf),
    .is_nan  (b_nan),
    .sign    (b_sign)
  );

  logic              spec;
  logic              res_sign;
  logic [31:0]       spec_r;
  logic [FLAG_W-1:0] spec_fl;
  logic [FLAG_W-1:0] core_fl;

  // Special-operand result, evaluated on the incoming request.
  always_comb begin
    res_sign = a_sign ^ b_sign;
    spec     = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;
    spec_r   = signed_zero(res_sign);
    spec_fl  = '0;
    if (a_nan || b_nan) begin
      spec_r         = QNAN;
      spec_fl[FL_IO] = 1'b1;
    end else if (bus.in_op == OP_MUL) begin
      if ((a_inf && b_zero) || (a_zero && b_inf)) begin
        spec_r         = QNAN;
        spec_fl[FL_IO] = 1'b1;
      end else if (a_inf || b_inf) begin
        spec_r = signed_inf(res_sign);
      end
    end else begin
      // Order matters: inf/0 resolves as inf/x (no dz), x/inf and 0/x fall
      // through to the signed-zero default.
      if ((a_zero && b_zero) || (a_inf && b_inf)) begin
        spec_r         = QNAN;
        spec_fl[FL_IO] = 1'b1;
      end else if (a_inf) begin
        spec_r = signed_inf(res_sign);
      end else if (b_zero) begin
        spec_r         = signed_inf(res_sign);
        spec_fl[FL_DZ] = 1'b1;
      end
    end
  end

  // Core flags as captured into the result register.
  always_comb begin
    core_fl        = '0;
    core_fl[FL_OF] = bus.core_of;
    core_fl[FL_UF] = bus.core_uf;
    core_fl[FL_I]  = bus.core_i;
  end

  // Next-state, counter and result-register update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    r_d     = r_q;
    fl_d    = fl_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d   = bus.in_a;
          b_d   = bus.in_b;
          sel_d = bus.in_op;
          if (spec) begin
            r_d     = spec_r;
            fl_d    = spec_fl;
            state_d = ST_HOLD;
          end else if (bus.in_op == OP_MUL) begin
            cnt_d   = MUL_LOAD;
            state_d = ST_WAIT_MUL;
          end else begin
            cnt_d   = DIV_LOAD;
            state_d = ST_WAIT_DIV;
          end
        end
      end
      ST_WAIT_MUL: begin
        if (cnt_q == CNT_ONE) begin
          r_d     = bus.core_r;
          fl_d    = core_fl;
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_WAIT_DIV: begin
        // A done on the final counted cycle still wins over the timeout.
        if (bus.core_done_div) begin
          r_d     = bus.core_r;
          fl_d    = core_fl;
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else if (cnt_q == CNT_ONE) begin
          r_d        = QNAN;
          fl_d       = '0;
          fl_d[FL_IO] = 1'b1;
          cnt_d      = '0;
          state_d    = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, latched operands and result register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 1'b0;
      r_q     <= '0;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      r_q     <= r_d;
      fl_q    <= fl_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.core_en   = (state_q == ST_WAIT_MUL) || (state_q == ST_WAIT_DIV);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.core_a    = a_q;
  assign bus.core_b    = b_q;
  assign bus.core_sel  = sel_q;
  assign bus.out_r     = r_q;
  assign bus.out_flags = fl_q;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Self-checking bench for fp_issue_ctrl: directed vector table, randomized
// transactions against a rule-level model, and reset corner cases.
module tb_fp_issue_ctrl;

  localparam int L = 4;
  localparam int T = 64;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  fp_issue_ctrl_if bus ();

  fp_issue_ctrl #(.MUL_LAT(L), .DIV_TIMEOUT(T)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef enum {K_ZERO, K_FIN, K_INF, K_NAN} kind_e;

  function automatic kind_e kind_of(input logic [31:0] x);
    if (x[30:23] == 8'h00) return K_ZERO;
    if (x[30:23] != 8'hFF) return K_FIN;
    return (x[22:0] == 23'h0) ? K_INF : K_NAN;
  endfunction

  // Result, flags, edge at which out_valid is first seen, core_en cycles.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic op,
                                input logic [31:0] cr, input logic [2:0] cf, input int done_at,
                                output logic [31:0] r, output logic [4:0] fl,
                                output int lat, output int en);
    kind_e ka, kb;
    logic [31:0] sz, si;
    ka = kind_of(a);
    kb = kind_of(b);
    sz = {a[31] ^ b[31], 31'h0};
    si = sz | 32'h7F80_0000;
    r = 32'h7FC0_0000; fl = 5'b0; lat = 1; en = 0;
    if (ka == K_NAN || kb == K_NAN) fl = 5'b10000;
    else if (op == 1'b0) begin
      if (ka == K_FIN && kb == K_FIN) begin
        r = cr; fl = {2'b00, cf}; lat = L + 1; en = L;
      end else if ((ka == K_INF && kb == K_ZERO) || (ka == K_ZERO && kb == K_INF)) fl = 5'b10000;
      else if (ka == K_INF || kb == K_INF) r = si;
      else r = sz;
    end else begin
      if (ka == K_FIN && kb == K_FIN) begin
        if (done_at >= 1 && done_at <= T) begin
          r = cr; fl = {2'b00, cf}; lat = done_at + 1; en = done_at;
        end else begin
          fl = 5'b10000; lat = T + 1; en = T;
        end
      end else if (ka == kb) fl = 5'b10000;
      else if (ka == K_INF) r = si;
      else if (kb == K_ZERO) begin r = si; fl = 5'b01000; end
      else r = sz;
    end
  endfunction

  // One full transaction: accept, wait, optional backpressure, handshake.
  // done_at = k pulses core_done_div so it is sampled on the k-th edge after accept.
  task automatic do_txn(input string nm, input logic [31:0] a, input logic [31:0] b, input logic op,
                        input logic [31:0] cr, input logic [2:0] cf, input int done_at, input int bp,
                        input logic [31:0] exp_r, input logic [4:0] exp_fl,
                        input int exp_lat, input int exp_en);
    int lat, en_cyc, bad;
    logic [31:0] r0;
    logic [4:0]  f0;
    @(negedge clk);
    check({nm, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_valid = 1'b1;
    bus.core_r = cr; {bus.core_of, bus.core_uf, bus.core_i} = cf;
    bus.out_ready = 1'b0; bus.core_done_div = 1'b0;
    @(negedge clk);
    lat = 0; en_cyc = 0; bad = 0;
    for (int k = 1; k <= T + 20; k++) begin
      if (bus.out_valid) begin lat = k; break; end
      if (bus.core_en) en_cyc++;
      if (bus.core_a !== a || bus.core_b !== b || bus.core_sel !== op || bus.in_ready !== 1'b0) bad++;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_a = $urandom; bus.in_b = $urandom; bus.in_op = 1'($urandom_range(0, 1));
      bus.core_done_div = (op == 1'b1) ? (k == done_at) : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.core_done_div = 1'b0;
    check({nm, ".latency"}, 32'(lat), 32'(exp_lat));
    check({nm, ".core_en_cycles"}, 32'(en_cyc), 32'(exp_en));
    check({nm, ".out_r"}, bus.out_r, exp_r);
    check({nm, ".out_flags"}, 32'(bus.out_flags), 32'(exp_fl));
    r0 = bus.out_r; f0 = bus.out_flags;
    for (int i = 0; i < bp; i++) begin
      bus.in_valid = 1'b1; bus.in_a = $urandom; bus.core_done_div = 1'b1;
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_r !== r0 ||
          bus.out_flags !== f0 || bus.core_a !== a || bus.core_b !== b) bad++;
    end
    check({nm, ".held_stable"}, 32'(bad), 32'd0);
    bus.in_valid = 1'b0; bus.core_done_div = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({nm, ".idle_after"}, {29'b0, bus.in_ready, bus.out_valid, bus.core_en}, 32'b100);
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        op;
    logic [31:0] cr;
    logic [2:0]  cf;
    int          done_at, bp;
    logic [31:0] exp_r;
    logic [4:0]  exp_fl;
    int          exp_lat, exp_en;
  } vec_t;

  function automatic logic [31:0] rand_operand();
    logic [31:0] x;
    int c;
    x = $urandom;
    c = $urandom_range(0, 9);
    if (c == 0) x[30:23] = 8'h00;
    else if (c == 1) begin x[30:23] = 8'hFF; x[22:0] = '0; end
    else if (c == 2) begin x[30:23] = 8'hFF; if (x[22:0] == 23'h0) x[0] = 1'b1; end
    else x[30:23] = 8'($urandom_range(1, 254));
    return x;
  endfunction

  logic [31:0] mr;
  logic [4:0]  mf;
  int          ml, me;
  vec_t        vecs[$];

  initial begin
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = 1'b0;
    bus.core_done_div = 1'b0; bus.core_r = '0;
    bus.core_of = 1'b0; bus.core_uf = 1'b0; bus.core_i = 1'b0;
    bus.out_ready = 1'b0;

    vecs = '{
      '{32'h40400000, 32'h40000000, 1'b0, 32'h40C00000, 3'b000, 0,  0, 32'h40C00000, 5'b00000, 5,  4},
      '{32'h3F800000, 32'h00000000, 1'b1, 32'h11111111, 3'b111, 0,  0, 32'h7F800000, 5'b01000, 1,  0},
      '{32'hFF800000, 32'h00000000, 1'b0, 32'h11111111, 3'b000, 0,  0, 32'h7FC00000, 5'b10000, 1,  0},
      '{32'h80000000, 32'h40A00000, 1'b0, 32'h11111111, 3'b000, 0,  1, 32'h80000000, 5'b00000, 1,  0},
      '{32'h40000000, 32'h3F800000, 1'b1, 32'h40000000, 3'b001, 20, 3, 32'h40000000, 5'b00001, 21, 20},
      '{32'h3F800000, 32'h40000000, 1'b1, 32'h22222222, 3'b111, 0,  0, 32'h7FC00000, 5'b10000, 65, 64},
      '{32'h3F800000, 32'h40400000, 1'b1, 32'h12345678, 3'b100, 64, 0, 32'h12345678, 5'b00100, 65, 64},
      '{32'h3F800000, 32'h40400000, 1'b1, 32'h3EAAAAAB, 3'b001, 1,  0, 32'h3EAAAAAB, 5'b00001, 2,  1},
      '{32'h7F800001, 32'h3F800000, 1'b0, 32'h11111111, 3'b000, 0,  0, 32'h7FC00000, 5'b10000, 1,  0},
      '{32'h00000001, 32'hC0000000, 1'b0, 32'h11111111, 3'b000, 0,  0, 32'h80000000, 5'b00000, 1,  0},
      '{32'hFF800000, 32'h40000000, 1'b1, 32'h11111111, 3'b000, 0,  0, 32'hFF800000, 5'b00000, 1,  0},
      '{32'h3F800000, 32'hFF800000, 1'b1, 32'h11111111, 3'b000, 0,  0, 32'h80000000, 5'b00000, 1,  0},
      '{32'h00000000, 32'h00000000, 1'b1, 32'h11111111, 3'b000, 0,  0, 32'h7FC00000, 5'b10000, 1,  0},
      '{32'hFF800000, 32'h80000000, 1'b1, 32'h11111111, 3'b000, 0,  0, 32'h7F800000, 5'b00000, 1,  0},
      '{32'h7F800000, 32'h80400000, 1'b0, 32'h11111111, 3'b000, 0,  0, 32'h7FC00000, 5'b10000, 1,  0},
      '{32'h80000000, 32'hC0000000, 1'b1, 32'h11111111, 3'b000, 0,  0, 32'h00000000, 5'b00000, 1,  0},
      '{32'h7E000000, 32'h7E000000, 1'b0, 32'h7F800000, 3'b110, 0,  2, 32'h7F800000, 5'b00110, 5,  4},
      '{32'hFFC00000, 32'h00000000, 1'b0, 32'h11111111, 3'b000, 0,  0, 32'h7FC00000, 5'b10000, 1,  0}
    };

    // Reset state, while asserted and after a release away from the edge.
    #12;
    check("reset_asserted", {bus.in_ready, bus.out_valid, bus.core_en, bus.core_sel},
          32'b1000);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    check("reset_release", {bus.in_ready, bus.out_valid, bus.core_en, bus.core_sel, 3'b0},
          32'b1000000);
    check("reset_regs", bus.core_a | bus.core_b | bus.out_r | 32'(bus.out_flags), 32'h0);

    foreach (vecs[i])
      do_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cr, vecs[i].cf,
             vecs[i].done_at, vecs[i].bp, vecs[i].exp_r, vecs[i].exp_fl,
             vecs[i].exp_lat, vecs[i].exp_en);

    // Reset in WAIT_DIV with a done pulse during reset: nothing must come out.
    @(negedge clk);
    bus.in_a = 32'h3F800000; bus.in_b = 32'h40400000; bus.in_op = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("midreset.in_wait_div", {bus.core_en, bus.core_sel, bus.in_ready}, 32'b110);
    arst_n = 1'b0;
    #1;
    check("midreset.async", {bus.core_en, bus.in_ready, bus.out_valid}, 32'b010);
    @(negedge clk);
    bus.core_r = 32'h55555555; bus.core_done_div = 1'b1;
    @(negedge clk);
    bus.core_done_div = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    check("midreset.outs_zero", bus.core_a | bus.core_b | bus.out_r | 32'(bus.out_flags) |
          32'({bus.core_en, bus.core_sel, bus.out_valid}), 32'h0);
    check("midreset.in_ready", 32'(bus.in_ready), 32'd1);
    ml = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) ml++;
    end
    check("midreset.no_result", 32'(ml), 32'd0);
    do_txn("after_reset_mul", 32'h40400000, 32'h40000000, 1'b0, 32'h40C00000, 3'b000, 0, 0,
           32'h40C00000, 5'b00000, L + 1, L);

    // Randomized transactions against the rule model.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra, rb, rcr;
      logic        rop;
      logic [2:0]  rcf;
      int          rdone;
      ra = rand_operand(); rb = rand_operand(); rop = 1'($urandom_range(0, 1));
      rcr = $urandom; rcf = 3'($urandom_range(0, 7));
      rdone = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, T);
      model(ra, rb, rop, rcr, rcf, rdone, mr, mf, ml, me);
      do_txn($sformatf("rnd%0d", n), ra, rb, rop, rcr, rcf, rdone, $urandom_range(0, 3),
             mr, mf, ml, me);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_issue_ctrl.md
# fp_issue_ctrl

Upstream issue and sequencing stage for the FP multiply/divide datapath. It accepts operand pairs over a valid/ready handshake and classifies them (zero, subnormal, infinity, NaN). Special cases are resolved locally, without using the core. Ordinary operands are held stable on the core inputs while it drives `en`/`sel`, waits the fixed multiply latency or the divider `done` pulse, then captures `R` and the flags into a valid/ready result register.

## Interface
- `MUL_LAT`, default 4: cycles `core_en` is held for a multiply before `core_r` is sampled (legal range 1..15).
- `DIV_TIMEOUT`, default 64: maximum cycles spent waiting for `core_done_div` (legal range 2..255).
- `clk  in  1`: single clock, rising edge.
- `arst_n  in  1`: asynchronous, active-low reset.
- `in_valid  in  1`, `in_ready  out  1`: request handshake.
- `in_a`, `in_b  in  32`: IEEE-754 single operands.
- `in_op  in  1`: 0 = multiply, 1 = divide (a/b).
- `core_a`, `core_b  out  32`: operands to the core; held for the whole operation.
- `core_en  out  1`, `core_sel  out  1`: core enable; `core_sel = in_op` as latched.
- `core_done_div  in  1`: divider completion pulse.
- `core_r  in  32`, `core_of`, `core_uf`, `core_i  in  1`: core result and flags.
- `out_valid  out  1`, `out_ready  in  1`: result handshake.
- `out_r  out  32`: result.
- `out_flags  out  5`: bit order {io, dz, of, uf, i}.

## Operation
- **States:**
  - IDLE: `in_ready` = 1.
  - WAIT_MUL: `core_en` = 1.
  - WAIT_DIV: `core_en` = 1.
  - HOLD: `out_valid` = 1.
- **Accept** when `in_valid & in_ready`. Operands and op are latched into `core_a/core_b/core_sel`. Next state:
  - HOLD if the operands are special; the result is written that same edge.
  - WAIT_MUL if op = 0; the counter is loaded with `MUL_LAT`.
  - WAIT_DIV if op = 1; the counter is loaded with `DIV_TIMEOUT`.
- **Classification:**
  - Exponent 0 is treated as zero (subnormals flushed, sign kept).
  - Exponent 0xFF with mantissa 0 is inf; with mantissa ≠ 0 it is NaN.
  - Result sign is `a[31]^b[31]`, except for NaN.
- **Special results** (flags are 0 unless listed):
  - Any NaN operand → `0x7FC00000`, io.
  - Multiply:
    - inf×0 → `0x7FC00000`, io.
    - inf×x → signed inf.
    - 0×x → signed zero.
  - Divide:
    - 0/0 and inf/inf → `0x7FC00000`, io.
    - finite/0 → signed inf, dz.
    - inf/x → signed inf.
    - x/inf → signed zero.
    - 0/x → signed zero.
- **WAIT_MUL:** the counter decrements each cycle. On the edge where the counter is 1, capture `core_r` and flags {0,0,`core_of`,`core_uf`,`core_i`}, then go to HOLD.
- **WAIT_DIV:** `core_done_div` high → capture as for multiply, then go to HOLD. If the counter reaches 1 with no done, write `0x7FC00000` with io and go to HOLD.
- **HOLD:** `out_r`/`out_flags` are stable until `out_valid & out_ready`, then go to IDLE.
- **Ignored inputs:**
  - `core_done_div` is ignored outside WAIT_DIV.
  - `in_valid` is ignored outside IDLE.

## Timing
- **Reset (async assert, sync release):** state = IDLE, all registered outputs and the counter = 0. After release `in_ready` = 1 and `out_valid` = 0.
- **Reset mid-operation:** the transaction is discarded; no result is produced.
- **Special path:** `out_valid` rises 1 edge after the accept edge.
- **Multiply path:**
  - `core_en` is high for exactly `MUL_LAT` cycles, starting the cycle after accept.
  - `out_valid` rises `MUL_LAT`+1 edges after the accept edge.
- **Divide path:** `out_valid` rises 1 edge after the edge that samples `core_done_div` = 1, or 1 edge after timeout.
- **Throughput:** one transaction in flight. Back-to-back best case is 2 cycles per special operation, since in HOLD→IDLE `in_ready` returns the cycle after the `out_ready` handshake.
- `core_a/core_b/core_sel` never change except on an accept edge.

## Structure
- Package `fp_issue_pkg` holds:
  - the state enum and op encoding (`OP_MUL`, `OP_DIV`);
  - `QNAN` = `32'h7FC00000`, `POS_INF` = `32'h7F800000`;
  - flag bit indices (`FL_IO`..`FL_I`);
  - the exponent and mantissa field widths.
- Sub-module `fp_classify` is combinational, one instance per operand. Outputs: `is_zero`, `is_inf`, `is_nan`, `sign`.
- The special-result mux and the FSM/counter live in `fp_issue_ctrl`.

## Test plan
- **Multiply, normal operands:** `0x40400000` × `0x40000000`, bench core returns `0x40C00000`.
  - `core_en` is high for exactly 4 cycles.
  - `out_valid` rises 5 edges after accept.
  - `out_r` = `0x40C00000`, flags = 0.
- **Divide by zero:** `0x3F800000` / `0x00000000`.
  - `core_en` never rises; `out_valid` rises after 1 edge.
  - `out_r` = `0x7F800000`, dz = 1.
- **Special multiplies:**
  - `0xFF800000` × `0x00000000` → `0x7FC00000`, io.
  - `0x80000000` × `0x40A00000` → `0x80000000`, flags 0.
- **Divide with backpressure:** `core_done_div` pulses 20 cycles after accept; `out_ready` is held low for 3 cycles.
  - `out_r`/`out_flags` are stable and `in_ready` = 0 throughout the 3 cycles.
  - IDLE is reached on the handshake.
- **Divide timeout:** done is never asserted.
  - HOLD is reached `DIV_TIMEOUT` edges after accept.
  - `out_r` = `0x7FC00000`, io = 1.
- **Reset mid-operation:** `arst_n` is pulled low in WAIT_DIV, then a done pulse arrives during reset.
  - All outputs are 0 and `in_ready` = 1 after release.
  - The next multiply completes normally.
